fir_seq_filter: RTL and testbench
=================================

FIR_SEQ_FILTER -- requirements
Module: fir_seq_filter

Interface
REQ-001 SHALL have parameter DW, default 8: signed input sample width.
REQ-002 SHALL have parameter CW, default 8: signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 4, legal range 2..64: filter length.
REQ-004 SHALL have parameter AW, default $clog2(TAPS): coefficient address width.
REQ-005 SHALL have parameter OW, default DW+CW+$clog2(TAPS): signed output width, full precision, never overflows.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 in_valid  input  1  sample present on x_in.
REQ-009 in_ready  output  1  block can accept a sample.
REQ-010 x_in  input  DW  signed input sample.
REQ-011 coef_we  input  1  coefficient write strobe.
REQ-012 coef_addr  input  AW  tap index to write.
REQ-013 coef_data  input  CW  signed coefficient value.
REQ-014 out_valid  output  1  y_out holds a completed result.
REQ-015 out_ready  input  1  downstream accepts y_out.
REQ-016 y_out  output  OW  signed filter result.

Function
REQ-017 SHALL compute y = sum over k=0..TAPS-1 of x[n-k]*c[k], where x[n] is the sample just accepted, using signed arithmetic sign-extended to OW.
REQ-018 SHALL use one multiplier and one accumulator, time-multiplexed over the taps.
REQ-019 SHALL implement states IDLE, MAC, OUT; IDLE->MAC on accept; MAC->OUT after exactly TAPS MAC cycles; OUT->IDLE on out_valid && out_ready.
REQ-020 in_ready SHALL be 1 only in IDLE; a sample is accepted on a cycle where in_valid && in_ready.
REQ-021 On accept, the delay line SHALL shift: x[0] <= x_in, x[k] <= x[k-1]; the accumulator SHALL clear to 0 and the tap index to 0.
REQ-022 Each MAC cycle SHALL add x[i]*c[i] to the accumulator and increment i, for i = 0..TAPS-1.
REQ-023 On entry to OUT, y_out SHALL load the accumulator and out_valid SHALL be 1; y_out SHALL stay stable while out_valid && !out_ready.
REQ-024 Latency: out_valid SHALL first be 1 exactly TAPS+1 cycles after the accept edge; maximum throughput is one sample per TAPS+2 cycles with out_ready tied high.
REQ-025 out_valid SHALL drop to 0 on the cycle after the handshake; y_out SHALL keep its last value.
REQ-026 A coefficient write (c[coef_addr] <= coef_data) SHALL occur only when coef_we is 1 in IDLE; writes in MAC or OUT SHALL be dropped silently.
REQ-027 A write with coef_addr >= TAPS SHALL be ignored.
REQ-028 When coef_we and a sample accept occur on the same IDLE cycle, both SHALL take effect, and the MAC pass SHALL use the newly written coefficient.
REQ-029 Samples offered while in_ready is 0 SHALL NOT enter the delay line.

Reset
REQ-030 While rst is 1: state = IDLE, delay line = 0, coefficients = 0, accumulator = 0, tap index = 0, y_out = 0, out_valid = 0, in_ready = 1 from the first cycle after release.
REQ-031 Reset asserted mid-MAC or mid-OUT SHALL abort the pass; no result SHALL be produced for the aborted sample.

Verification
REQ-032 Impulse test: TAPS=4, c={1,2,3,4}, inputs 1,0,0,0 with out_ready=1 -> y_out sequence 1,2,3,4, each out_valid at accept+5.
REQ-033 Extreme test: all c=-128, all x=-128, four samples -> 4th y_out = 65536 with no overflow (OW=18).
REQ-034 Backpressure test: out_ready=0 for 10 cycles in OUT -> y_out and out_valid stable, in_ready=0 throughout; release -> one handshake, then IDLE.
REQ-035 Busy write test: coef_we with c[0]=7 during MAC -> dropped; next result uses the old c[0]. The same write in IDLE together with an accept -> the result uses 7.
REQ-036 Reset test: rst pulse at MAC cycle 2 -> no out_valid, all outputs 0; the next impulse with reloaded coefficients reproduces REQ-032.

Source files
------------

// File: rtl/fir_seq_filter.sv
// fir_seq_filter: sequential FIR filter, one multiplier and one accumulator shared across all taps
module fir_seq_filter #(
   parameter int DW   = 8,
   parameter int CW   = 8,
   parameter int TAPS = 4,
   parameter int AW   = $clog2(TAPS),
   parameter int OW   = DW + CW + $clog2(TAPS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] x_in,
   input  logic                 coef_we,
   input  logic [AW-1:0]        coef_addr,
   input  logic signed [CW-1:0] coef_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] y_out
);
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state, nxt;
   logic signed [DW-1:0]    x_dl [TAPS];
   logic signed [CW-1:0]    c [TAPS];
   logic signed [OW-1:0]    acc;
   logic [AW-1:0]           i;
   logic signed [DW+CW-1:0] prod;
   logic signed [OW-1:0]    sum;
   logic                    accept, last;
   assign in_ready  = state == IDLE;
   assign out_valid = state == OUT;
   assign accept    = in_valid && in_ready;
   assign last      = i == AW'(TAPS - 1);
   assign prod      = x_dl[i] * c[i];
   assign sum       = acc + OW'(prod);
   // state register; reset aborts any pass in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   // next state: accept starts a pass, last tap finishes it, handshake retires the result
   always_comb begin
      nxt = state;
      if (state == IDLE && accept) nxt = MAC;
      else if (state == MAC && last) nxt = OUT;
      else if (state == OUT && out_ready) nxt = IDLE;
   end
   // datapath: delay line shift, MAC pass, result capture and coefficient writes
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            x_dl[k] <= '0;
            c[k]    <= '0;
         end
         acc   <= '0;
         i     <= '0;
         y_out <= '0;
      end else begin
         if (accept) begin
            x_dl[0] <= x_in;
            for (int k = 1; k < TAPS; k++) x_dl[k] <= x_dl[k-1];
            acc <= '0;
            i   <= '0;
         end
         if (state == MAC) begin
            acc <= sum;
            i   <= i + AW'(1);
            if (last) y_out <= sum;
         end
         if (coef_we && in_ready && 32'(coef_addr) < TAPS) c[coef_addr] <= coef_data;
      end
endmodule

// File: tb/tb_fir_seq_filter.sv
// tb_fir_seq_filter: directed scoreboard bench for fir_seq_filter
module tb_fir_seq_filter;
   localparam int TAPS = 4;
   localparam int OW   = 18;
   logic                 clk = 0, rst = 1, in_valid = 0, coef_we = 0, out_ready = 1;
   logic                 in_ready, out_valid;
   logic signed [7:0]    x_in = 0, coef_data = 0;
   logic [1:0]           coef_addr = 0;
   logic signed [OW-1:0] y_out;
   int checks = 0, errs = 0, cyc = 0, prev_acc = 0;
   bit gap_on = 0, ov_d = 0;
   logic signed [OW-1:0] exp_q [$];
   int acc_q [$];

   fir_seq_filter dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // monitor: latency on rising out_valid, result value on every handshake
   always @(negedge clk)
      if (rst) ov_d = 0;
      else begin
         if (out_valid && !ov_d) begin
            if (acc_q.size() == 0) begin
               checks++; errs++;
               $display("FAIL unexpected_out_valid: got y_out %0d with no pending sample", y_out);
            end else chk("latency", cyc - acc_q.pop_front(), TAPS + 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errs++;
               $display("FAIL unexpected_result: got %0d with empty scoreboard", y_out);
            end else chk("y_out", y_out, exp_q.pop_front());
         end
         ov_d = out_valid;
      end

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("in_ready_wait", in_ready, 1);
   endtask

   task automatic send(input logic signed [7:0] x, input logic signed [OW-1:0] e,
                       input bit we = 0, input logic [1:0] a = 0, input logic signed [7:0] d = 0);
      int n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      if (gap_on) chk("throughput_gap", cyc - prev_acc, TAPS + 2);
      prev_acc = cyc;
      in_valid = 1; x_in = x; coef_we = we; coef_addr = a; coef_data = d;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      @(posedge clk); #1;
      in_valid = 0; coef_we = 0;
   endtask

   task automatic load(input logic signed [7:0] v [4]);
      for (int k = 0; k < 4; k++) begin
         coef_we = 1; coef_addr = 2'(k); coef_data = v[k];
         @(posedge clk); #1;
      end
      coef_we = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 100) begin @(posedge clk); #1; n++; end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 0;
      @(posedge clk); #1;
      chk("in_ready_after_rst", in_ready, 1);
      // impulse response with back-to-back samples
      load('{1, 2, 3, 4});
      send(1, 1);
      gap_on = 1;
      send(0, 2); send(0, 3); send(0, 4);
      gap_on = 0;
      drain();
      // extreme values: full-precision output
      load('{-128, -128, -128, -128});
      send(-128, 16384); send(-128, 32768); send(-128, 49152); send(-128, 65536);
      drain();
      // backpressure: x = {5,-128,-128,-128}, c = {1,2,3,4}
      load('{1, 2, 3, 4});
      out_ready = 0;
      send(5, -1147);
      begin
         int n = 0;
         while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      end
      for (int k = 0; k < 10; k++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_y_out", y_out, -1147);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1;
      @(posedge clk); #1;
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
      chk("post_hs_y_out_held", y_out, -1147);
      // write during MAC is dropped: x = {2,5,-128,-128}, old c0 = 1
      send(2, -884);
      coef_we = 1; coef_addr = 0; coef_data = 7;
      @(posedge clk); #1;
      coef_we = 0;
      drain();
      // write together with accept takes effect: x = {2,2,5,-128}, c0 = 7
      send(2, -479, 1, 0, 7);
      drain();
      // reset in the middle of a pass
      send(1, 0);
      @(posedge clk); #1;
      rst = 1;
      exp_q.delete();
      acc_q.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_y_out", y_out, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      repeat (8) @(posedge clk);
      #1;
      chk("after_abort_out_valid", out_valid, 0);
      chk("after_abort_y_out", y_out, 0);
      load('{1, 2, 3, 4});
      send(1, 1); send(0, 2); send(0, 3); send(0, 4);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule
